// File: rtl/life_engine_if.sv
// Command, rule, write and read-port signals of the life_engine core.
// master = controller side, slave = engine side.
interface life_engine_if #(
    parameter int LOG_W = 4,
    parameter int LOG_H = 4
);
    localparam int AW = LOG_W + LOG_H;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [8:0]    birth_mask;
    logic [8:0]    survive_mask;
    logic          wrap;
    logic          seed_bit;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          busy;
    logic          done;
    logic [15:0]   gen_count;
    logic [AW:0]   pop_count;

    modport master (
        output cmd_valid, cmd_op, birth_mask, survive_mask, wrap, seed_bit,
               wr_en, wr_addr, wr_data, rd_addr,
        input  cmd_ready, rd_data, busy, done, gen_count, pop_count
    );

    modport slave (
        input  cmd_valid, cmd_op, birth_mask, survive_mask, wrap, seed_bit,
               wr_en, wr_addr, wr_data, rd_addr,
        output cmd_ready, rd_data, busy, done, gen_count, pop_count
    );
endinterface

// File: rtl/life_engine.sv
// Game-of-Life core: ping-pong W x H board, one cell per clock for CLEAR/SEED/STEP,
// runtime birth/survive masks, torus or dead edges, generation and population counters.
module life_engine #(
    parameter int LOG_W = 4,
    parameter int LOG_H = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    life_engine_if.slave  bus
);
    localparam int W   = 1 << LOG_W;
    localparam int H   = 1 << LOG_H;
    localparam int N   = W * H;
    localparam int AW  = LOG_W + LOG_H;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    // Encodings match cmd_op so an accepted op loads straight into the state.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_SEED  = 2'b01,
        ST_STEP  = 2'b10,
        ST_IDLE  = 2'b11
    } state_t;

    state_t             state;
    logic               sel;
    logic [1:0][N-1:0]  board;
    logic [AW-1:0]      index;
    logic [AW:0]        acc;
    logic [8:0]         birth_q;
    logic [8:0]         survive_q;
    logic               wrap_q;
    logic               busy_q;
    logic               done_q;
    logic               rd_q;
    logic [15:0]        gen_q;
    logic [AW:0]        pop_q;

    logic [N-1:0]       front;
    logic [LOG_W-1:0]   cx, nx;
    logic [LOG_H-1:0]   cy, ny;
    logic               edge_x, edge_y;
    logic [3:0]         ncount;
    logic               step_val;
    logic               new_val;
    logic               accept;

    assign front  = board[sel];
    assign cx     = index[LOG_W-1:0];
    assign cy     = index[AW-1:LOG_W];
    assign accept = bus.cmd_valid && (state == ST_IDLE) && (bus.cmd_op != 2'b11);

    assign bus.cmd_ready = ~busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_q;
    assign bus.gen_count = gen_q;
    assign bus.pop_count = pop_q;

    // Neighbour i of the 3x3 window: column offset i%3-1, row offset i/3-1.
    always_comb begin
        ncount = '0;
        nx     = '0;
        ny     = '0;
        edge_x = 1'b0;
        edge_y = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i != 4) begin
                nx     = cx + LOG_W'(i % 3) - LOG_W'(1);
                ny     = cy + LOG_H'(i / 3) - LOG_H'(1);
                edge_x = ((i % 3) == 0 && cx == '0) || ((i % 3) == 2 && cx == '1);
                edge_y = ((i / 3) == 0 && cy == '0) || ((i / 3) == 2 && cy == '1);
                if (wrap_q || !(edge_x || edge_y))
                    ncount = ncount + {3'b000, front[{ny, nx}]};
            end
        end
        step_val = front[index] ? survive_q[ncount] : birth_q[ncount];
        case (state)
            ST_SEED: new_val = bus.seed_bit;
            ST_STEP: new_val = step_val;
            default: new_val = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            board     <= '0;
            index     <= '0;
            acc       <= '0;
            birth_q   <= '0;
            survive_q <= '0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            gen_q     <= '0;
            pop_q     <= '0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= front[bus.rd_addr];
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= state_t'(bus.cmd_op);
                        index     <= '0;
                        acc       <= '0;
                        birth_q   <= bus.birth_mask;
                        survive_q <= bus.survive_mask;
                        wrap_q    <= bus.wrap;
                        busy_q    <= 1'b1;
                    end else if (bus.wr_en) begin
                        board[sel][bus.wr_addr] <= bus.wr_data;
                    end
                end
                ST_CLEAR, ST_SEED, ST_STEP: begin
                    board[~sel][index] <= new_val;
                    acc   <= acc + (AW+1)'(new_val);
                    index <= index + 1'b1;
                    if (index == LAST) begin
                        sel    <= ~sel;
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pop_q  <= acc + (AW+1)'(new_val);
                        gen_q  <= (state == ST_STEP) ? gen_q + 16'd1 : '0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine on a 16x16 board: rule vectors plus
// back-to-back, latch, write-drop, reserved-op, seed, clear and reset sequences.
module tb_life_engine;
    localparam int LOG_W = 4;
    localparam int LOG_H = 4;
    localparam int N     = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    life_engine_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();

    life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         wrap;
        logic [8:0]   birth;
        logic [8:0]   survive;
        logic [255:0] init;
        logic [255:0] exp_b;
        int           pop;
    } vec_t;

    vec_t         vecs[6];
    logic [255:0] blink_v, blink_h, edge_v, glider, corners, seed_exp, rb;
    int           nbusy, edges, dones;
    logic         saw_done, done_after;

    function automatic logic [255:0] c(input int x, input int y);
        logic [255:0] b;
        b = '0;
        b[y*16 + x] = 1'b1;
        return b;
    endfunction

    task automatic check_b(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [255:0] b);
        for (int i = 0; i < N; i++) begin
            if (b[i]) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 8'(i);
                bus.wr_data = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic read_board(output logic [255:0] b);
        b = '0;
        for (int i = 0; i < N; i++) begin
            bus.rd_addr = 8'(i);
            @(posedge clk);
            #1 b[i] = bus.rd_data;
        end
    endtask

    // hook 1: zero the masks, 2: write cell 0 while busy, 3: assert reset
    task automatic run_cmd(input logic [1:0] op, input int hook_at, input int hook,
                           output int nb, output logic sd, output logic da);
        bus.cmd_op    = op;
        bus.seed_bit  = 1'b0;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        nb = 0;
        while (bus.busy && nb < 1000) begin
            bus.seed_bit = nb[0];
            if (nb == hook_at) begin
                if (hook == 1) begin
                    bus.birth_mask   = '0;
                    bus.survive_mask = '0;
                end else if (hook == 2) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = '0;
                    bus.wr_data = 1'b1;
                end else if (hook == 3) begin
                    rst_n = 1'b0;
                    #1;
                    break;
                end
            end
            @(posedge clk);
            #1 nb++;
            bus.wr_en = 1'b0;
        end
        sd = bus.done;
        @(posedge clk);
        #1 da = bus.done;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.birth_mask = 9'h008;
        bus.survive_mask = 9'h00C;
        bus.wrap = 1'b1;
        bus.seed_bit = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = 1'b0;
        bus.rd_addr = '0;

        blink_v = c(7,6) | c(7,7) | c(7,8);
        blink_h = c(6,7) | c(7,7) | c(8,7);
        edge_v  = c(0,6) | c(0,7) | c(0,8);
        glider  = c(1,0) | c(2,1) | c(0,2) | c(1,2) | c(2,2);
        corners = c(0,0) | c(15,0) | c(0,15) | c(15,15);
        seed_exp = '0;
        for (int i = 0; i < N; i++) seed_exp[i] = (i % 2 == 1);

        vecs[0] = '{1'b1, 9'h008, 9'h00C, blink_v, blink_h, 3};
        vecs[1] = '{1'b0, 9'h008, 9'h00C, edge_v, c(0,7) | c(1,7), 2};
        vecs[2] = '{1'b1, 9'h008, 9'h00C, edge_v, c(15,7) | c(0,7) | c(1,7), 3};
        vecs[3] = '{1'b1, 9'h000, 9'h000, blink_v, '0, 0};
        vecs[4] = '{1'b1, 9'h008, 9'h00C, corners, corners, 4};
        vecs[5] = '{1'b0, 9'h008, 9'h00C, corners, '0, 0};

        do_reset();
        check_v("rst_busy", int'(bus.busy), 0);
        check_v("rst_done", int'(bus.done), 0);
        check_v("rst_ready", int'(bus.cmd_ready), 1);
        check_v("rst_gen", int'(bus.gen_count), 0);
        check_v("rst_pop", int'(bus.pop_count), 0);
        read_board(rb);
        check_b("rst_board", rb, '0);

        foreach (vecs[v]) begin
            do_reset();
            bus.wrap = vecs[v].wrap;
            bus.birth_mask = vecs[v].birth;
            bus.survive_mask = vecs[v].survive;
            load(vecs[v].init);
            check_v($sformatf("v%0d_pre_pop", v), int'(bus.pop_count), 0);
            run_cmd(2'b10, -1, 0, nbusy, saw_done, done_after);
            check_v($sformatf("v%0d_busy_cycles", v), nbusy, 256);
            check_v($sformatf("v%0d_done", v), int'(saw_done), 1);
            check_v($sformatf("v%0d_done_pulse", v), int'(done_after), 0);
            check_v($sformatf("v%0d_gen", v), int'(bus.gen_count), 1);
            check_v($sformatf("v%0d_pop", v), int'(bus.pop_count), vecs[v].pop);
            read_board(rb);
            check_b($sformatf("v%0d_board", v), rb, vecs[v].exp_b);
        end

        // masks latched at accept, zeroed mid-command
        do_reset();
        bus.wrap = 1'b1;
        bus.birth_mask = 9'h008;
        bus.survive_mask = 9'h00C;
        load(blink_v);
        run_cmd(2'b10, 10, 1, nbusy, saw_done, done_after);
        check_v("latch_pop", int'(bus.pop_count), 3);
        read_board(rb);
        check_b("latch_board", rb, blink_h);

        // write while busy dropped (masks still zero on the inputs, restore)
        bus.birth_mask = 9'h008;
        bus.survive_mask = 9'h00C;
        run_cmd(2'b10, 20, 2, nbusy, saw_done, done_after);
        check_v("wrbusy_gen", int'(bus.gen_count), 2);
        read_board(rb);
        check_b("wrbusy_board", rb, blink_v);

        // reserved op never accepted
        run_cmd(2'b11, -1, 0, nbusy, saw_done, done_after);
        check_v("op11_busy", nbusy, 0);
        check_v("op11_done", int'(saw_done | done_after), 0);
        check_v("op11_gen", int'(bus.gen_count), 2);
        read_board(rb);
        check_b("op11_board", rb, blink_v);

        // 64 back-to-back STEPs, each accepted in the previous done cycle
        do_reset();
        bus.wrap = 1'b1;
        load(glider);
        bus.cmd_op = 2'b10;
        bus.cmd_valid = 1'b1;
        edges = 0;
        dones = 0;
        while (dones < 64 && edges < 20000) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.done) begin
                dones++;
                if (dones == 64) bus.cmd_valid = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        check_v("glider_dones", dones, 64);
        check_v("glider_edges", edges, 64 * 257);
        check_v("glider_gen", int'(bus.gen_count), 64);
        check_v("glider_pop", int'(bus.pop_count), 5);
        read_board(rb);
        check_b("glider_board", rb, glider);

        // SEED with seed_bit = index[0]
        run_cmd(2'b01, -1, 0, nbusy, saw_done, done_after);
        check_v("seed_done", int'(saw_done), 1);
        check_v("seed_pop", int'(bus.pop_count), 128);
        check_v("seed_gen", int'(bus.gen_count), 0);
        read_board(rb);
        check_b("seed_board", rb, seed_exp);

        // CLEAR
        run_cmd(2'b00, -1, 0, nbusy, saw_done, done_after);
        check_v("clear_busy_cycles", nbusy, 256);
        check_v("clear_pop", int'(bus.pop_count), 0);
        read_board(rb);
        check_b("clear_board", rb, '0);

        // reset in the middle of a SEED, with a seeded board in front
        run_cmd(2'b01, -1, 0, nbusy, saw_done, done_after);
        run_cmd(2'b01, 100, 3, nbusy, saw_done, done_after);
        check_v("midrst_cycle", nbusy, 100);
        check_v("midrst_busy", int'(bus.busy), 0);
        check_v("midrst_done", int'(saw_done | done_after), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_v("midrst_ready", int'(bus.cmd_ready), 1);
        check_v("midrst_pop", int'(bus.pop_count), 0);
        read_board(rb);
        check_b("midrst_board", rb, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
